// File: rtl/zone_led_spi_tx.sv
// Snapshots the zone bytes at frame start and sends header + zones MSB-first over SPI, then a latch strobe.
// Build option TEMPORAL_FILTER_EN: each zone byte is slewed from its previous value toward the snapshot.

module zone_led_spi_tx #(
  parameter int         ZONES   = 360,
  parameter int         CLK_DIV = 4,
  parameter logic [7:0] HDR     = 8'hA5,
  parameter int         LAT_W   = 4
) (
  input  logic               i_pix_clk,
  input  logic               rst_n,
  input  logic               r_Vsync_0,
  input  logic [ZONES*8-1:0] buf_360_flatted,
  output logic               o_led_sclk,
  output logic               o_led_mosi,
  output logic               o_led_cs_n,
  output logic               o_led_lat,
  output logic               o_busy,
  output logic               o_frame_drop
);
  localparam int IDX_W  = $clog2(ZONES + 1);
  localparam int DIV_W  = $clog2(CLK_DIV) + 1;
  localparam int LAT_CW = $clog2(LAT_W) + 1;
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(ZONES);
  localparam logic [DIV_W-1:0]  DIV_LOAD = DIV_W'(CLK_DIV - 1);
  localparam logic [LAT_CW-1:0] LAT_LOAD = LAT_CW'(LAT_W - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_LATCH} state_t;
  state_t r_state, w_state_nxt;

  logic              r_vs_d;
  logic              r_sclk;
  logic              r_cs_n;
  logic              r_frame_drop;
  logic [DIV_W-1:0]  r_div;
  logic [2:0]        r_bit;
  logic [IDX_W-1:0]  r_byte_idx;
  logic [7:0]        r_shreg;
  logic [LAT_CW-1:0] r_lat_cnt;
  logic [7:0]        r_snap [ZONES];

  logic       w_start, w_div_tc, w_bit_end, w_byte_end, w_last, w_zone_load, w_lat_tc;
  logic [7:0] w_snap_k, w_zone_out;

  assign w_start     = r_Vsync_0 & ~r_vs_d;
  assign w_div_tc    = (r_div == '0);
  assign w_bit_end   = (r_state == S_SHIFT) & r_sclk & w_div_tc;
  assign w_byte_end  = w_bit_end & (r_bit == 3'd0);
  assign w_last      = w_byte_end & (r_byte_idx == IDX_LAST);
  assign w_zone_load = w_byte_end & ~w_last;
  assign w_lat_tc    = (r_lat_cnt == '0);
  // r_byte_idx already points at the next zone to send (byte n carries zone n-1)
  assign w_snap_k    = r_snap[r_byte_idx];

`ifdef TEMPORAL_FILTER_EN
  logic [7:0] r_prev [ZONES];
  logic [7:0] w_prev_k;
  logic [8:0] w_diff;
  logic [7:0] w_step;

  assign w_prev_k = r_prev[r_byte_idx];
  assign w_diff   = (w_snap_k > w_prev_k) ? ({1'b0, w_snap_k} - {1'b0, w_prev_k})
                                          : ({1'b0, w_prev_k} - {1'b0, w_snap_k});
  assign w_step   = 8'((w_diff + 9'd3) >> 2);

  always_comb begin
    w_zone_out = w_prev_k;
    if (w_snap_k > w_prev_k)      w_zone_out = w_prev_k + w_step;
    else if (w_snap_k < w_prev_k) w_zone_out = w_prev_k - w_step;
  end

  always_ff @(posedge i_pix_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < ZONES; k++) r_prev[k] <= '0;
    end else if (w_zone_load) begin
      r_prev[r_byte_idx] <= w_zone_out;
    end
  end
`else
  assign w_zone_out = w_snap_k;
`endif

  always_ff @(posedge i_pix_clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_state_nxt = S_LOAD;
      S_LOAD:  w_state_nxt = S_SHIFT;
      S_SHIFT: if (w_last) w_state_nxt = S_LATCH;
      S_LATCH: if (w_lat_tc) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_pix_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vs_d       <= 1'b0;
      r_sclk       <= 1'b0;
      r_cs_n       <= 1'b1;
      r_frame_drop <= 1'b0;
      r_div        <= '0;
      r_bit        <= '0;
      r_byte_idx   <= '0;
      r_shreg      <= '0;
      r_lat_cnt    <= '0;
      for (int k = 0; k < ZONES; k++) r_snap[k] <= '0;
    end else begin
      r_vs_d       <= r_Vsync_0;
      r_frame_drop <= w_start & (r_state != S_IDLE);
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            for (int k = 0; k < ZONES; k++) r_snap[k] <= buf_360_flatted[k*8 +: 8];
          end
        end
        S_LOAD: begin
          r_cs_n     <= 1'b0;
          r_sclk     <= 1'b0;
          r_byte_idx <= '0;
          r_shreg    <= HDR;
          r_bit      <= 3'd7;
          r_div      <= DIV_LOAD;
        end
        S_SHIFT: begin
          if (!w_div_tc) begin
            r_div <= r_div - 1'b1;
          end else begin
            r_div  <= DIV_LOAD;
            r_sclk <= ~r_sclk;
            if (r_sclk) begin
              if (r_bit != 3'd0) begin
                r_bit   <= r_bit - 1'b1;
                r_shreg <= {r_shreg[6:0], 1'b0};
              end else if (w_last) begin
                r_cs_n    <= 1'b1;
                r_lat_cnt <= LAT_LOAD;
              end else begin
                r_bit      <= 3'd7;
                r_byte_idx <= r_byte_idx + 1'b1;
                r_shreg    <= w_zone_out;
              end
            end
          end
        end
        S_LATCH: begin
          if (!w_lat_tc) r_lat_cnt <= r_lat_cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  // mosi only moves when the shift register does, i.e. at the start of a low phase
  assign o_led_sclk   = r_sclk;
  assign o_led_mosi   = ~r_cs_n & r_shreg[7];
  assign o_led_cs_n   = r_cs_n;
  assign o_led_lat    = (r_state == S_LATCH);
  assign o_busy       = (r_state != S_IDLE);
  assign o_frame_drop = r_frame_drop;

endmodule

// File: tb/tb_zone_led_spi_tx.sv
// Bench for zone_led_spi_tx: an SPI receiver model collects bytes and compares them to a list built from the buffer at frame start.
module tb_zone_led_spi_tx;
  localparam int ZONES = 360;
  localparam int CLK_DIV = 4;
  localparam int LAT_W = 4;
  localparam logic [7:0] HDR = 8'hA5;
  localparam int BUSY_EXP = (ZONES + 1) * 8 * 2 * CLK_DIV + 1 + LAT_W;
  localparam int BUSY_F = (ZONES + 1) * 8 * 2 + 1 + 2;
  localparam int PKT_MAX = 30000;

  logic clk = 1'b0;
  logic rst_n, i_vs, i_vs_f;
  logic [ZONES*8-1:0] i_buf;
  logic s_sclk, s_mosi, s_cs_n, s_lat, s_busy, s_drop;
  logic f_sclk, f_mosi, f_cs_n, f_lat, f_busy, f_drop;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  zone_led_spi_tx #(.ZONES(ZONES), .CLK_DIV(CLK_DIV), .HDR(HDR), .LAT_W(LAT_W)) u_dut (
    .i_pix_clk(clk), .rst_n(rst_n), .r_Vsync_0(i_vs), .buf_360_flatted(i_buf),
    .o_led_sclk(s_sclk), .o_led_mosi(s_mosi), .o_led_cs_n(s_cs_n), .o_led_lat(s_lat),
    .o_busy(s_busy), .o_frame_drop(s_drop));

  zone_led_spi_tx #(.ZONES(ZONES), .CLK_DIV(1), .HDR(HDR), .LAT_W(2)) u_fast (
    .i_pix_clk(clk), .rst_n(rst_n), .r_Vsync_0(i_vs_f), .buf_360_flatted(i_buf),
    .o_led_sclk(f_sclk), .o_led_mosi(f_mosi), .o_led_cs_n(f_cs_n), .o_led_lat(f_lat),
    .o_busy(f_busy), .o_frame_drop(f_drop));

  logic [7:0] rx_q[$];
  logic [7:0] fq[$];
  logic [7:0] exp_q[$];
  int mprev [2][ZONES];

  int m_busy = 0, m_lat = 0, m_drop = 0, m_viol = 0, m_nbit = 0;
  logic [7:0] m_byte = '0;
  logic m_sclk_q = 1'b0, m_mosi_q = 1'b0;

  always @(negedge clk) begin
    if (s_cs_n) m_nbit = 0;
    else if (s_sclk && !m_sclk_q) begin
      m_byte = {m_byte[6:0], s_mosi};
      m_nbit++;
      if (m_nbit == 8) begin rx_q.push_back(m_byte); m_nbit = 0; end
    end
    if (s_sclk && s_mosi !== m_mosi_q) m_viol++;
    if (s_busy) m_busy++;
    if (s_lat) m_lat++;
    if (s_drop) m_drop++;
    m_sclk_q = s_sclk;
    m_mosi_q = s_mosi;
  end

  int f_busy_n = 0, f_lat_n = 0, f_drop_n = 0, f_viol = 0, f_nbit = 0, f_rise = 0, f_notog = 0;
  logic [7:0] f_byte = '0;
  logic f_sclk_q = 1'b0, f_mosi_q = 1'b0, f_cs_q = 1'b1;

  always @(negedge clk) begin
    if (f_cs_n) f_nbit = 0;
    else if (f_sclk && !f_sclk_q) begin
      f_rise++;
      f_byte = {f_byte[6:0], f_mosi};
      f_nbit++;
      if (f_nbit == 8) begin fq.push_back(f_byte); f_nbit = 0; end
    end
    if (!f_cs_n && !f_cs_q && f_sclk === f_sclk_q) f_notog++;
    if (f_sclk && f_mosi !== f_mosi_q) f_viol++;
    if (f_busy) f_busy_n++;
    if (f_lat) f_lat_n++;
    if (f_drop) f_drop_n++;
    f_sclk_q = f_sclk;
    f_mosi_q = f_mosi;
    f_cs_q = f_cs_n;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic clr_mon();
    rx_q.delete(); fq.delete();
    m_busy = 0; m_lat = 0; m_drop = 0; m_viol = 0;
    f_busy_n = 0; f_lat_n = 0; f_drop_n = 0; f_viol = 0; f_rise = 0; f_notog = 0;
  endtask

  task automatic rand_buf();
    for (int k = 0; k < ZONES; k++) i_buf[k*8 +: 8] = 8'($urandom);
  endtask

  // Expected packet: header, then each zone as seen at the start edge (slewed when filtering).
  task automatic build_exp(input int inst);
    int b;
    int p;
    exp_q.delete();
    exp_q.push_back(HDR);
    for (int k = 0; k < ZONES; k++) begin
      b = int'(i_buf[k*8 +: 8]);
      p = mprev[inst][k];
`ifdef TEMPORAL_FILTER_EN
      if (b > p)      b = p + (b - p + 3) / 4;
      else if (b < p) b = p - (p - b + 3) / 4;
`endif
      if (p < 0) b = 0;
      mprev[inst][k] = b;
      exp_q.push_back(8'(b));
    end
  endtask

  function automatic int nbad_of(input logic [7:0] got[$], input int n);
    int bad = 0;
    for (int i = 0; i < n; i++)
      if (i >= got.size() || got[i] !== exp_q[i]) bad++;
    return bad;
  endfunction

  task automatic send_packet(input string nm, input int drop_at, input int hold);
    int cyc;
    int z;
    build_exp(0);
    clr_mon();
    i_vs = 1'b1;
    @(negedge clk);
    check({nm, "_load_busy"}, s_busy, 1);
    check({nm, "_load_cs_n"}, s_cs_n, 1);
    @(negedge clk);
    check({nm, "_shift_cs_n"}, s_cs_n, 0);
    cyc = 2;
    while (s_busy && cyc < PKT_MAX) begin
      @(negedge clk);
      cyc++;
      for (int j = 0; j < 4; j++) begin
        z = $urandom_range(ZONES - 1);
        i_buf[z*8 +: 8] = 8'($urandom);
      end
      if (cyc == hold) i_vs = 1'b0;
      if (drop_at != 0 && cyc == drop_at) i_vs = 1'b1;
      if (drop_at != 0 && cyc == drop_at + 2) i_vs = 1'b0;
    end
    check({nm, "_timeout"}, cyc < PKT_MAX, 1);
    check({nm, "_busy_cycles"}, m_busy, BUSY_EXP);
    check({nm, "_lat_cycles"}, m_lat, LAT_W);
    check({nm, "_drops"}, m_drop, (drop_at != 0) ? 1 : 0);
    check({nm, "_len"}, rx_q.size(), ZONES + 1);
    check({nm, "_bytes_bad"}, nbad_of(rx_q, ZONES + 1), 0);
    check({nm, "_mosi_while_high"}, m_viol, 0);
    check({nm, "_cs_n_end"}, s_cs_n, 1);
  endtask

  task automatic send_fast();
    int cyc;
    build_exp(1);
    clr_mon();
    i_vs_f = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 3) i_vs_f = 1'b0;
    end while (f_busy && cyc < PKT_MAX);
    check("fast_timeout", cyc < PKT_MAX, 1);
    check("fast_busy_cycles", f_busy_n, BUSY_F);
    check("fast_lat_cycles", f_lat_n, 2);
    check("fast_rises", f_rise, (ZONES + 1) * 8);
    check("fast_no_toggle", f_notog, 0);
    check("fast_mosi_while_high", f_viol, 0);
    check("fast_len", fq.size(), ZONES + 1);
    check("fast_bytes_bad", nbad_of(fq, ZONES + 1), 0);
    check("fast_drops", f_drop_n, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    rst_n = 1'b0; i_vs = 1'b0; i_vs_f = 1'b0; i_buf = '0;
    foreach (mprev[i, k]) mprev[i][k] = 0;
    repeat (3) @(negedge clk);
    check("rst_sclk", s_sclk, 0);
    check("rst_mosi", s_mosi, 0);
    check("rst_cs_n", s_cs_n, 1);
    check("rst_lat", s_lat, 0);
    check("rst_busy", s_busy, 0);
    check("rst_drop", s_drop, 0);
    check("rst_fast_cs_n", f_cs_n, 1);
    rst_n = 1'b1;
    @(negedge clk);

    // Packet aborted by reset once 100 bytes have gone out
    rand_buf();
    build_exp(0);
    clr_mon();
    i_vs = 1'b1;
    cyc = 0;
    while (rx_q.size() < 100 && cyc < PKT_MAX) begin
      @(negedge clk);
      cyc++;
      if (cyc == 3) i_vs = 1'b0;
    end
    check("abort_timeout", cyc < PKT_MAX, 1);
    check("abort_bytes_bad", nbad_of(rx_q, 100), 0);
    #1 rst_n = 1'b0;
    #1;
    check("abort_sclk", s_sclk, 0);
    check("abort_mosi", s_mosi, 0);
    check("abort_cs_n", s_cs_n, 1);
    check("abort_lat", s_lat, 0);
    check("abort_busy", s_busy, 0);
    foreach (mprev[i, k]) mprev[i][k] = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_busy", s_busy, 0);

    // Sparse pattern, buffer scrambled during SHIFT, extra frame start at cycle 10000
    i_buf = '0;
    i_buf[7:0] = 8'h81;
    i_buf[ZONES*8-1 -: 8] = 8'h7E;
    send_packet("p1", 10000, 3);
    check("p1_hdr", rx_q[0], 8'hA5);
    check("p1_zone0", rx_q[1], exp_q[1]);
    check("p1_zone359", rx_q[ZONES], exp_q[ZONES]);

    // Random content, vsync held high for 200 cycles: a single start only
    rand_buf();
    send_packet("p2", 0, 200);

    rand_buf();
    send_fast();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
